// File: rtl/text_console_writer.sv
// Port-B writer for the text RAM: character cells, cursor,
// clear-screen and hardware scroll via read-modify-write.
module text_console_writer #(
   parameter int unsigned COLS           = 80,
   parameter int unsigned ROWS           = 30,
   parameter logic [15:0] TEXT_BASE      = 16'h0000,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        charValid,
   input  logic [7:0]  charData,
   output logic        charReady,
   input  logic [7:0]  colorAttr,
   input  logic        clearReq,
   output logic [6:0]  cursorCol,
   output logic [4:0]  cursorRow,
   output logic        busy,
   output logic [15:0] addressB,
   output logic [15:0] writeDataB,
   output logic        writeEnableB,
   input  logic [15:0] readDataB
);

   typedef enum logic [2:0] {
      IDLE, WRITE, SCROLL_RD, SCROLL_WR, BLANK, CLEAR
   } state_t;

   localparam int CW = $clog2(COLS * ROWS + 1);
   localparam state_t RESET_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;
   localparam logic [CW-1:0] CNT_CELLS  = CW'(COLS * ROWS);
   localparam logic [CW-1:0] CNT_SCROLL = CW'((ROWS - 1) * COLS - 1);
   localparam logic [CW-1:0] CNT_BLANK  = CW'(COLS - 1);
   localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
   localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);
   localparam logic [15:0] COLS16    = 16'(COLS);
   localparam logic [15:0] LAST_BASE = 16'(TEXT_BASE + (ROWS - 1) * COLS);

   state_t        state;
   logic [CW-1:0] cnt;
   logic [7:0]    attrLatched;
   logic          clearPending;
   logic          advance;
   logic [15:0]   rowBase;
   logic [15:0]   wrData;
   logic [15:0]   cellAddr;
   logic          printable;
   logic          lastRow;

   assign cellAddr  = rowBase + {9'd0, cursorCol};
   assign printable = (charData >= 8'h20) && (charData <= 8'h7E);
   assign lastRow   = (cursorRow == LAST_ROW);
   assign busy      = (state != IDLE);
   assign charReady = rst_n && (state == IDLE) && !clearReq && !clearPending;
   // Scroll copies the registered RAM read straight into the write cycle.
   assign writeDataB = (state == SCROLL_WR) ? readDataB : wrData;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= RESET_STATE;
         cnt          <= '0;
         attrLatched  <= 8'h00;
         clearPending <= 1'b0;
         advance      <= 1'b0;
         cursorCol    <= 7'd0;
         cursorRow    <= 5'd0;
         rowBase      <= TEXT_BASE;
         addressB     <= TEXT_BASE;
         wrData       <= 16'h0000;
         writeEnableB <= 1'b0;
      end else begin
         if (clearReq && state != IDLE) clearPending <= 1'b1;
         unique case (state)
            IDLE: begin
               writeEnableB <= 1'b0;
               if (clearReq || clearPending) begin
                  clearPending <= 1'b0;
                  state        <= CLEAR;
                  cursorCol    <= 7'd0;
                  cursorRow    <= 5'd0;
                  rowBase      <= TEXT_BASE;
               end else if (charValid) begin
                  unique case (1'b1)
                     printable: begin
                        addressB     <= cellAddr;
                        wrData       <= {colorAttr, charData};
                        writeEnableB <= 1'b1;
                        advance      <= 1'b1;
                        state        <= WRITE;
                     end
                     (charData == 8'h0A): begin
                        cursorCol <= 7'd0;
                        if (lastRow) begin
                           state       <= SCROLL_RD;
                           addressB    <= TEXT_BASE + COLS16;
                           cnt         <= '0;
                           attrLatched <= colorAttr;
                        end else begin
                           cursorRow <= cursorRow + 5'd1;
                           rowBase   <= rowBase + COLS16;
                        end
                     end
                     (charData == 8'h0D): cursorCol <= 7'd0;
                     (charData == 8'h08): begin
                        if (cursorCol != 7'd0) begin
                           cursorCol    <= cursorCol - 7'd1;
                           addressB     <= cellAddr - 16'd1;
                           wrData       <= {colorAttr, 8'h20};
                           writeEnableB <= 1'b1;
                           advance      <= 1'b0;
                           state        <= WRITE;
                        end
                     end
                     (charData == 8'h0C): begin
                        state     <= CLEAR;
                        cursorCol <= 7'd0;
                        cursorRow <= 5'd0;
                        rowBase   <= TEXT_BASE;
                     end
                     default: ;
                  endcase
               end
            end
            WRITE: begin
               writeEnableB <= 1'b0;
               state        <= IDLE;
               if (advance) begin
                  if (cursorCol == LAST_COL) begin
                     cursorCol <= 7'd0;
                     if (lastRow) begin
                        state       <= SCROLL_RD;
                        addressB    <= TEXT_BASE + COLS16;
                        cnt         <= '0;
                        attrLatched <= colorAttr;
                     end else begin
                        cursorRow <= cursorRow + 5'd1;
                        rowBase   <= rowBase + COLS16;
                     end
                  end else begin
                     cursorCol <= cursorCol + 7'd1;
                  end
               end
            end
            SCROLL_RD: begin
               addressB     <= addressB - COLS16;
               writeEnableB <= 1'b1;
               state        <= SCROLL_WR;
            end
            SCROLL_WR: begin
               if (cnt == CNT_SCROLL) begin
                  state        <= BLANK;
                  addressB     <= LAST_BASE;
                  wrData       <= {attrLatched, 8'h20};
                  writeEnableB <= 1'b1;
                  cnt          <= '0;
               end else begin
                  addressB     <= addressB + COLS16 + 16'd1;
                  writeEnableB <= 1'b0;
                  cnt          <= cnt + CW'(1);
                  state        <= SCROLL_RD;
               end
            end
            BLANK: begin
               if (cnt == CNT_BLANK) begin
                  writeEnableB <= 1'b0;
                  state        <= IDLE;
               end else begin
                  addressB <= addressB + 16'd1;
                  cnt      <= cnt + CW'(1);
               end
            end
            CLEAR: begin
               // First cycle samples the attribute and writes cell 0.
               if (!writeEnableB) begin
                  addressB     <= TEXT_BASE;
                  wrData       <= {colorAttr, 8'h20};
                  attrLatched  <= colorAttr;
                  writeEnableB <= 1'b1;
                  cnt          <= CW'(1);
               end else if (cnt == CNT_CELLS) begin
                  writeEnableB <= 1'b0;
                  state        <= IDLE;
               end else begin
                  addressB <= addressB + 16'd1;
                  wrData   <= {attrLatched, 8'h20};
                  cnt      <= cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
